divider_taint_track_1bit: RTL and testbench
===========================================

DIVIDER_TAINT_TRACK_1BIT -- requirements
Module: divider_taint_track_1bit

Interface
REQ-001 Parameter SHALL be: WIDTH, default 64, operand width in bits.
REQ-002 Port SHALL be: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port SHALL be: rst  input  1  reset, synchronous and active-high.
REQ-004 Port SHALL be: start  input  1  request a division; sampled only in IDLE.
REQ-005 Port SHALL be: start_t  input  1  taint of start.
REQ-006 Port SHALL be: dividend  input  WIDTH  unsigned dividend, sampled with start.
REQ-007 Port SHALL be: dividend_t  input  1  taint of dividend (whole word).
REQ-008 Port SHALL be: divisor  input  WIDTH  unsigned divisor, sampled with start.
REQ-009 Port SHALL be: divisor_t  input  1  taint of divisor (whole word).
REQ-010 Port SHALL be: quotient  output  WIDTH  result quotient.
REQ-011 Port SHALL be: quotient_t  output  1  taint of quotient.
REQ-012 Port SHALL be: remainder  output  WIDTH  result remainder.
REQ-013 Port SHALL be: remainder_t  output  1  taint of remainder.
REQ-014 Port SHALL be: busy  output  1  high while in ITER.
REQ-015 Port SHALL be: busy_t  output  1  taint of busy.
REQ-016 Port SHALL be: quotientDone  output  1  one-cycle result-valid pulse.
REQ-017 Port SHALL be: quotientDone_t  output  1  taint of quotientDone.
REQ-018 Port SHALL be: divByZero  output  1  divisor was zero; valid with quotientDone, held until next start.
REQ-019 Port SHALL be: divByZero_t  output  1  taint of divByZero.

Function
REQ-020 Block SHALL implement a restoring shift-subtract divider, split into a control FSM and a datapath, with states IDLE, ITER and DONE.
REQ-021 IDLE with start=1 on edge E0 SHALL latch dividend, divisor and input taints, clear the partial remainder (WIDTH+1 bits), clear the step counter, and go to ITER.
REQ-022 ITER, each edge: shift {partial remainder, dividend reg} left 1; if partial remainder >= divisor, subtract divisor and set quotient LSB to 1, else set it to 0; increment counter.
REQ-023 After the WIDTH-th ITER edge (E_WIDTH) the FSM SHALL enter DONE; quotientDone=1 for exactly the cycle following E_WIDTH (Moore output); the next edge SHALL return to IDLE.
REQ-024 Latency SHALL be fixed at WIDTH+1 cycles from the E0 sampling edge to quotientDone high; it SHALL be independent of operand values.
REQ-025 quotient, remainder and divByZero SHALL hold their values from DONE through IDLE until the next accepted start.
REQ-026 start SHALL be ignored in ITER and DONE; no operand or taint register changes.
REQ-027 divisor=0 SHALL give quotient all ones, remainder=dividend and divByZero=1, with no special-case early exit (same latency).
REQ-028 Taint at E0: data_t = dividend_t | divisor_t | start_t; quotient_t and remainder_t SHALL equal the latched data_t and be held with the results.
REQ-029 divByZero_t SHALL equal the latched divisor_t | start_t.
REQ-030 busy_t and quotientDone_t SHALL equal the latched start_t (timing depends only on start, not on data).
REQ-031 Taint outputs SHALL be 1-bit conservative over-approximations; no taint SHALL clear except via rst or a new accepted start.

Reset
REQ-032 rst=1 on any edge SHALL force IDLE and clear the counter; quotient, remainder, busy, quotientDone and divByZero SHALL be 0; all *_t outputs SHALL be 0.
REQ-033 rst asserted mid-ITER SHALL abort the operation; no quotientDone pulse for that operation; start is accepted on the first edge with rst=0.
REQ-034 rst and start high on the same edge: rst SHALL win.

Verification (WIDTH=8)
REQ-035 100/7, all taints 0, start at E0 -> quotientDone high after E8 only; quotient=14, remainder=2, divByZero=0, all *_t=0.
REQ-036 55/0 -> quotient=0xFF, remainder=55, divByZero=1 with quotientDone after E8.
REQ-037 255/1 with dividend_t=1 -> quotient=255, remainder=0; quotient_t=remainder_t=1; divByZero_t=quotientDone_t=busy_t=0.
REQ-038 Start 9/2 with start_t=1, then pulse start with 200/3 during ITER -> quotient=4, remainder=1 (second start ignored); busy_t, quotientDone_t, quotient_t and divByZero_t all 1.
REQ-039 rst at E4 of 100/7 -> all outputs 0 next cycle, no quotientDone; a new start 50/5 -> quotient=10, remainder=0 after 9 cycles.

Source files
------------

// File: rtl/divider_taint_track_1bit.sv
// Restoring shift-subtract divider (unsigned, fixed WIDTH-cycle iteration) with
// 1-bit conservative taint tracking on results, status and handshake outputs.
module divider_taint_track_1bit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic             dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic             divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic             quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic             remainder_t,
  output logic             busy,
  output logic             busy_t,
  output logic             quotientDone,
  output logic             quotientDone_t,
  output logic             divByZero,
  output logic             divByZero_t
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_step;
  logic             w_last;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_divisor;
  logic             r_dbz;
  logic             r_data_t;
  logic             r_dz_t;
  logic             r_start_t;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    busy         = 1'b0;
    quotientDone = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ITER;
        end
      end
      ITER: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        quotientDone = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  // The WIDTH+1-bit partial remainder only exists in its shifted form; once
  // restored it is always below the divisor, so WIDTH bits are enough to hold.
  assign w_shift = {r_rem, r_dq[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_divisor});
  assign w_diff  = w_shift[WIDTH-1:0] - r_divisor;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dq      <= '0;
      r_divisor <= '0;
      r_dbz     <= 1'b0;
      r_data_t  <= 1'b0;
      r_dz_t    <= 1'b0;
      r_start_t <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dq      <= dividend;
      r_divisor <= divisor;
      r_dbz     <= 1'b0;
      r_data_t  <= dividend_t | divisor_t | start_t;
      r_dz_t    <= divisor_t | start_t;
      r_start_t <= start_t;
    end else if (w_step) begin
      r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
      r_dq  <= {r_dq[WIDTH-2:0], w_ge};
      r_cnt <= r_cnt + CW'(1);
      // Zero divisor runs the full iteration and naturally yields all-ones / dividend.
      if (w_last) begin
        r_dbz <= (r_divisor == '0);
      end
    end
  end

  assign quotient       = r_dq;
  assign remainder      = r_rem;
  assign divByZero      = r_dbz;
  assign quotient_t     = r_data_t;
  assign remainder_t    = r_data_t;
  assign divByZero_t    = r_dz_t;
  assign busy_t         = r_start_t;
  assign quotientDone_t = r_start_t;

endmodule

// File: tb/tb_divider_taint_track_1bit.sv
// Scoreboard bench for divider_taint_track_1bit at WIDTH=8: stimulus pushes
// reference results, a negedge monitor pops and compares on quotientDone.
module tb_divider_taint_track_1bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, start_t;
  logic [W-1:0] dividend, divisor;
  logic         dividend_t, divisor_t;
  logic [W-1:0] quotient, remainder;
  logic         quotient_t, remainder_t;
  logic         busy, busy_t, quotientDone, quotientDone_t, divByZero, divByZero_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         dt;
    logic         zt;
    logic         st;
    int           t0;
  } exp_t;

  exp_t sb[$];

  divider_taint_track_1bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .start(start), .start_t(start_t),
    .dividend(dividend), .dividend_t(dividend_t),
    .divisor(divisor), .divisor_t(divisor_t),
    .quotient(quotient), .quotient_t(quotient_t),
    .remainder(remainder), .remainder_t(remainder_t),
    .busy(busy), .busy_t(busy_t),
    .quotientDone(quotientDone), .quotientDone_t(quotientDone_t),
    .divByZero(divByZero), .divByZero_t(divByZero_t)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: plain integer division, zero divisor defined as all-ones / dividend.
  function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                 input logic dvd_t, input logic dvs_t, input logic st, input int t0);
    exp_t e;
    if (dvs == 0) begin
      e.q = '1; e.r = dvd; e.dbz = 1'b1;
    end else begin
      e.q = dvd / dvs; e.r = dvd % dvs; e.dbz = 1'b0;
    end
    e.dt = dvd_t | dvs_t | st;
    e.zt = dvs_t | st;
    e.st = st;
    e.t0 = t0;
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((busy || quotientDone) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles", busy, quotientDone, n);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_quotient"}, quotient, '0);
    chk({tag, "_remainder"}, remainder, '0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, quotientDone, 0);
    chk({tag, "_dbz"}, divByZero, 0);
    chk({tag, "_taints"}, {quotient_t, remainder_t, busy_t, quotientDone_t, divByZero_t}, '0);
  endtask

  // Issue one division; glitch>=0 pulses a bogus start (tainted) that many cycles into ITER.
  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic dvd_t, input logic dvs_t, input logic st, input int glitch);
    wait_idle();
    sb.push_back(model(dvd, dvs, dvd_t, dvs_t, st, cyc));
    $display("issue %0d/%0d taints dvd=%0b dvs=%0b st=%0b glitch=%0d", dvd, dvs, dvd_t, dvs_t, st, glitch);
    start = 1'b1; dividend = dvd; divisor = dvs;
    dividend_t = dvd_t; divisor_t = dvs_t; start_t = st;
    @(negedge clk);
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    dividend_t = 1'b0; divisor_t = 1'b0; start_t = 1'b0;
    if (glitch >= 0) begin
      repeat (glitch) @(negedge clk);
      start = 1'b1; dividend = W'($urandom); divisor = W'($urandom);
      dividend_t = 1'b1; divisor_t = 1'b1; start_t = 1'b1;
      @(negedge clk);
      start = 1'b0; dividend_t = 1'b0; divisor_t = 1'b0; start_t = 1'b0;
    end
  endtask

  // Monitor: compares results on quotientDone, busy during ITER, and hold afterwards.
  initial begin
    exp_t e;
    logic hold_pending = 1'b0;
    logic [W-1:0] hq, hr;
    logic hz;
    forever begin
      @(negedge clk);
      if (hold_pending) begin
        hold_pending = 1'b0;
        chk("hold_quotient", quotient, hq);
        chk("hold_remainder", remainder, hr);
        chk("hold_dbz", divByZero, hz);
      end
      if (quotientDone) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", quotientDone, 0);
        end else begin
          e = sb.pop_front();
          $display("done q=%0d r=%0d dbz=%0b exp q=%0d r=%0d dbz=%0b", quotient, remainder, divByZero, e.q, e.r, e.dbz);
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("divByZero", divByZero, e.dbz);
          chk("quotient_t", quotient_t, e.dt);
          chk("remainder_t", remainder_t, e.dt);
          chk("divByZero_t", divByZero_t, e.zt);
          chk("quotientDone_t", quotientDone_t, e.st);
          chk("busy_t_done", busy_t, e.st);
          chk("busy_in_done", busy, 0);
          chk_int("latency", cyc - e.t0, W + 1);
          hold_pending = 1'b1; hq = e.q; hr = e.r; hz = e.dbz;
        end
      end else if (sb.size() > 0) begin
        if (cyc > sb[0].t0 + W + 1) begin
          e = sb.pop_front();
          chk_int("done_timeout", cyc - e.t0, W + 1);
        end else if (cyc > sb[0].t0 && cyc <= sb[0].t0 + W) begin
          if (busy !== 1'b1 || busy_t !== sb[0].st) begin
            chk("busy_iter", {busy, busy_t}, {1'b1, sb[0].st});
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; start_t = 1'b0;
    dividend = '0; divisor = '0; dividend_t = 1'b0; divisor_t = 1'b0;
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst = 1'b0;

    issue(8'd100, 8'd7, 1'b0, 1'b0, 1'b0, -1);
    issue(8'd55, 8'd0, 1'b0, 1'b0, 1'b0, -1);
    issue(8'd255, 8'd1, 1'b1, 1'b0, 1'b0, -1);
    issue(8'd9, 8'd2, 1'b0, 1'b0, 1'b1, 2);
    issue(8'd0, 8'd5, 1'b0, 1'b1, 1'b0, 7);
    issue(8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 8);
    issue(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, -1);

    // Abort mid-ITER: no done for the aborted op, restart on the first rst=0 edge.
    wait_idle();
    $display("abort 100/7 with rst at E4");
    start = 1'b1; dividend = 8'd100; divisor = 8'd7; start_t = 1'b1; dividend_t = 1'b1;
    @(negedge clk);
    start = 1'b0; start_t = 1'b0; dividend_t = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    all_zero("abort");
    rst = 1'b0;
    issue(8'd50, 8'd5, 1'b0, 1'b0, 1'b0, -1);

    // rst and start on the same edge: rst wins.
    wait_idle();
    @(negedge clk);
    $display("rst with start same edge");
    rst = 1'b1; start = 1'b1; dividend = 8'd77; divisor = 8'd3; start_t = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; start_t = 1'b0;
    all_zero("rst_start");
    repeat (2) @(negedge clk);
    chk("rst_start_idle", busy, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      issue(a, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1);
    end

    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
